// File: rtl/text_scan_sequencer.sv
// Raster timing, text-buffer fetch and CPU write arbitration for the VGA text pipeline.
// Optional cursor blink on the fetched cell is enabled by defining CURSOR_BLINK_EN.
module text_scan_sequencer #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned COLS     = 80,
   parameter int unsigned ROWS     = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_wr_valid,
   output logic        cpu_wr_ready,
   input  logic [11:0] cpu_wr_addr,
   input  logic [7:0]  cpu_wr_data,
   input  logic [11:0] cursor_addr,
   output logic [11:0] tb_addr,
   output logic        tb_we,
   output logic [7:0]  tb_wdata,
   input  logic [7:0]  tb_rdata,
   output logic [7:0]  caracter,
   output logic [2:0]  columna,
   output logic [3:0]  fila,
   output logic        hsync,
   output logic        vsync,
   output logic        VGA_blank
);

   localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0]  H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [11:0] CELLS  = 12'(COLS * ROWS);
   localparam logic [11:0] COLS_W = 12'(COLS);

   logic [9:0]  h, v;
   logic [11:0] row_base;
   logic        h_last, v_last;
   logic        fetch, fetch_d;
   logic [11:0] fetch_addr;
   logic        wr_fire;
   logic [11:0] addr_hold;
   logic        hs_raw, vs_raw, bl_raw;
   logic        hs1, vs1, bl1;
   logic [2:0]  col1;
   logic [3:0]  fil1;
   logic [7:0]  cap_char;

   always_comb begin
      h_last     = (h == H_LAST);
      v_last     = (v == V_LAST);
      fetch      = (v < V_ACT) && (h < H_ACT) && (h[2:0] == 3'd0);
      fetch_addr = row_base + {5'd0, h[9:3]};
      hs_raw     = !((h >= HS_BEG) && (h <= HS_END));
      vs_raw     = !((v >= VS_BEG) && (v <= VS_END));
      bl_raw     = (h >= H_ACT) || (v >= V_ACT);
   end

   // row_base tracks row*COLS by accumulation, stepping after the 16th line of each text row
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h        <= '0;
         v        <= '0;
         row_base <= '0;
      end else if (h_last) begin
         h <= '0;
         if (v_last) begin
            v        <= '0;
            row_base <= '0;
         end else begin
            v <= v + 10'd1;
            if ((v[3:0] == 4'hF) && (v < V_ACT))
               row_base <= row_base + COLS_W;
         end
      end else begin
         h <= h + 10'd1;
      end
   end

   // Buffer port: display fetch wins; other cycles serve the CPU, else hold the address
   always_comb begin
      cpu_wr_ready = rst_n && !fetch;
      wr_fire      = cpu_wr_valid && cpu_wr_ready;
      tb_we        = wr_fire && (cpu_wr_addr < CELLS);
      tb_wdata     = cpu_wr_data;
      if (!rst_n)
         tb_addr = '0;
      else if (fetch)
         tb_addr = fetch_addr;
      else if (wr_fire)
         tb_addr = cpu_wr_addr;
      else
         tb_addr = addr_hold;
   end

`ifdef CURSOR_BLINK_EN
   logic [5:0]  frame_cnt;
   logic [11:0] fetch_idx_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt   <= '0;
         fetch_idx_d <= '0;
      end else begin
         if (h_last && v_last)
            frame_cnt <= frame_cnt + 6'd1;
         fetch_idx_d <= fetch_addr;
      end
   end

   always_comb begin
      cap_char = tb_rdata;
      if (frame_cnt[5] && (fetch_idx_d == cursor_addr))
         cap_char = 8'hDB;
   end
`else
   logic unused_cursor;

   always_comb begin
      unused_cursor = ^cursor_addr;
      cap_char      = tb_rdata;
   end
`endif

   // Two-stage pipe so the sync/blank/glyph position line up with the captured character
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_hold <= '0;
         fetch_d   <= 1'b0;
         hs1       <= 1'b1;
         vs1       <= 1'b1;
         bl1       <= 1'b1;
         col1      <= '0;
         fil1      <= '0;
         hsync     <= 1'b1;
         vsync     <= 1'b1;
         VGA_blank <= 1'b1;
         columna   <= '0;
         fila      <= '0;
         caracter  <= '0;
      end else begin
         addr_hold <= tb_addr;
         fetch_d   <= fetch;
         hs1       <= hs_raw;
         vs1       <= vs_raw;
         bl1       <= bl_raw;
         col1      <= h[2:0];
         fil1      <= v[3:0];
         hsync     <= hs1;
         vsync     <= vs1;
         VGA_blank <= bl1;
         columna   <= col1;
         fila      <= fil1;
         if (fetch_d)
            caracter <= cap_char;
      end
   end

endmodule

// File: tb/tb_text_scan_sequencer.sv
// Bench for text_scan_sequencer: full-size instance for line timing, fetch and CPU writes,
// plus a shrunken-raster instance for frame timing and the CURSOR_BLINK_EN cursor.
module tb_text_scan_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned pos   = 0;
   logic        mem_init;

   // Full-size instance
   logic        rst_n, cpu_wr_valid, cpu_wr_ready, tb_we, hsync, vsync, VGA_blank;
   logic [11:0] cpu_wr_addr, cursor_addr, tb_addr;
   logic [7:0]  cpu_wr_data, tb_wdata, tb_rdata, caracter;
   logic [2:0]  columna;
   logic [3:0]  fila;
   logic [7:0]  mem [4096];

   text_scan_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
      .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
      .cursor_addr(cursor_addr),
      .tb_addr(tb_addr), .tb_we(tb_we), .tb_wdata(tb_wdata), .tb_rdata(tb_rdata),
      .caracter(caracter), .columna(columna), .fila(fila),
      .hsync(hsync), .vsync(vsync), .VGA_blank(VGA_blank)
   );

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
      end else begin
         if (tb_we) mem[tb_addr] <= tb_wdata;
         tb_rdata <= mem[tb_addr];
      end
   end

   // Shrunken instance: 22 cycles/line, 36 lines/frame, 2x2 cells
   logic        rst_s_n, rdy_s, we_s, hs_s, vs_s, bl_s;
   logic [11:0] addr_s;
   logic [7:0]  wdata_s, rdata_s, char_s;
   logic [2:0]  col_s;
   logic [3:0]  fil_s;
   logic [7:0]  mem_s [4096];

   text_scan_sequencer #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .COLS(2), .ROWS(2)
   ) dut_s (
      .clk(clk), .rst_n(rst_s_n),
      .cpu_wr_valid(1'b0), .cpu_wr_ready(rdy_s),
      .cpu_wr_addr(12'd0), .cpu_wr_data(8'd0),
      .cursor_addr(12'd3),
      .tb_addr(addr_s), .tb_we(we_s), .tb_wdata(wdata_s), .tb_rdata(rdata_s),
      .caracter(char_s), .columna(col_s), .fila(fil_s),
      .hsync(hs_s), .vsync(vs_s), .VGA_blank(bl_s)
   );

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) mem_s[i] <= 8'(i);
      end else begin
         if (we_s) mem_s[addr_s] <= wdata_s;
         rdata_s <= mem_s[addr_s];
      end
   end

   typedef struct {
      int unsigned h;
      int unsigned v;
      logic        hs;
      logic        bl;
      logic [2:0]  col;
      logic [3:0]  fil;
      logic        chk;
      logic [7:0]  ch;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int unsigned h, input int unsigned v, input logic hs, input logic bl,
                      input logic [2:0] col, input logic [3:0] fil, input logic chk, input logic [7:0] ch);
      vec_t e;
      e.h = h; e.v = v; e.hs = hs; e.bl = bl; e.col = col; e.fil = fil; e.chk = chk; e.ch = ch;
      vq.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic goto(input int unsigned target);
      while (pos < target) begin
         @(negedge clk);
         pos++;
      end
   endtask

   task automatic run_vec(input int unsigned i);
      goto(vq[i].v * 800 + vq[i].h + 2);
      check($sformatf("v%0d_hsync", i), 32'(hsync), 32'(vq[i].hs));
      check($sformatf("v%0d_vsync", i), 32'(vsync), 32'd1);
      check($sformatf("v%0d_blank", i), 32'(VGA_blank), 32'(vq[i].bl));
      check($sformatf("v%0d_columna", i), 32'(columna), 32'(vq[i].col));
      check($sformatf("v%0d_fila", i), 32'(fila), 32'(vq[i].fil));
      if (vq[i].chk)
         check($sformatf("v%0d_caracter", i), 32'(caracter), 32'(vq[i].ch));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n1, hs_cnt, fall1, fall2, vs_low;
      int          hs_first;
      logic        prev;
      logic [7:0]  exp_cursor;

      // line 0 vectors
      add(  0, 0, 1, 0, 3'd0, 4'd0, 1, 8'h00);
      add(  5, 0, 1, 0, 3'd5, 4'd0, 1, 8'h00);
      add( 17, 0, 1, 0, 3'd1, 4'd0, 1, 8'h02);
      add(639, 0, 1, 0, 3'd7, 4'd0, 1, 8'h4F);
      add(640, 0, 1, 1, 3'd0, 4'd0, 0, 8'h00);
      add(655, 0, 1, 1, 3'd7, 4'd0, 0, 8'h00);
      add(656, 0, 0, 1, 3'd0, 4'd0, 0, 8'h00);
      add(751, 0, 0, 1, 3'd7, 4'd0, 0, 8'h00);
      add(752, 0, 1, 1, 3'd0, 4'd0, 0, 8'h00);
      add(799, 0, 1, 1, 3'd7, 4'd0, 0, 8'h00);
      n1 = vq.size();
      // later rows (cell 5 rewritten to 0x41 before these)
      add( 41, 15, 1, 0, 3'd1, 4'd15, 1, 8'h41);
      add(  0, 16, 1, 0, 3'd0, 4'd0,  1, 8'h50);
      add(639, 31, 1, 0, 3'd7, 4'd15, 1, 8'h9F);
      add( 17, 35, 1, 0, 3'd1, 4'd3,  1, 8'hA2);

      rst_n = 1'b0; rst_s_n = 1'b0; mem_init = 1'b1;
      cpu_wr_valid = 1'b1; cpu_wr_addr = 12'd3; cpu_wr_data = 8'h55; cursor_addr = 12'hFFF;
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_blank", 32'(VGA_blank), 32'd1);
      check("rst_caracter", 32'(caracter), 32'd0);
      check("rst_columna", 32'(columna), 32'd0);
      check("rst_fila", 32'(fila), 32'd0);
      check("rst_tb_we", 32'(tb_we), 32'd0);
      check("rst_tb_addr", 32'(tb_addr), 32'd0);
      check("rst_ready", 32'(cpu_wr_ready), 32'd0);
      check("rst_no_write", 32'(mem[3]), 32'h03);
      cpu_wr_valid = 1'b0;

      rst_n = 1'b1; pos = 0;
      for (int unsigned i = 0; i < n1; i++) run_vec(i);

      // write colliding with a fetch slot at h=8, line 1
      goto(808);
      cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h005; cpu_wr_data = 8'h41;
      #1;
      check("wr_stall_ready", 32'(cpu_wr_ready), 32'd0);
      check("wr_stall_we", 32'(tb_we), 32'd0);
      check("wr_stall_fetch_addr", 32'(tb_addr), 32'd1);
      goto(809); #1;
      check("wr_ready", 32'(cpu_wr_ready), 32'd1);
      check("wr_we", 32'(tb_we), 32'd1);
      check("wr_addr", 32'(tb_addr), 32'h005);
      check("wr_data", 32'(tb_wdata), 32'h41);
      goto(810);
      cpu_wr_valid = 1'b0;
      #1;
      check("idle_we", 32'(tb_we), 32'd0);
      check("idle_addr_hold", 32'(tb_addr), 32'h005);
      check("wr_mem", 32'(mem[5]), 32'h41);

      // out-of-range write accepted and dropped
      goto(820);
      cpu_wr_valid = 1'b1; cpu_wr_addr = 12'd2400; cpu_wr_data = 8'h99;
      #1;
      check("oor_ready", 32'(cpu_wr_ready), 32'd1);
      check("oor_we", 32'(tb_we), 32'd0);
      goto(821);
      cpu_wr_valid = 1'b0;
      check("oor_mem", 32'(mem[2400]), 32'h60);

      // hsync width and position over line 2
      hs_cnt = 0; hs_first = -1;
      for (int unsigned p = 1602; p <= 2401; p++) begin
         goto(p);
         if (!hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(p - 1602);
         end
      end
      check("hsync_low_cycles", 32'(hs_cnt), 32'd96);
      check("hsync_start", 32'(hs_first), 32'd656);

      for (int unsigned i = n1; i < vq.size(); i++) run_vec(i);

      // reset with a write pending at v=36, h=300
      goto(36 * 800 + 300);
      cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h010; cpu_wr_data = 8'h77; rst_n = 1'b0;
      #1;
      check("mrst_ready", 32'(cpu_wr_ready), 32'd0);
      check("mrst_we", 32'(tb_we), 32'd0);
      check("mrst_addr", 32'(tb_addr), 32'd0);
      @(negedge clk);
      check("mrst_hsync", 32'(hsync), 32'd1);
      check("mrst_vsync", 32'(vsync), 32'd1);
      check("mrst_blank", 32'(VGA_blank), 32'd1);
      check("mrst_caracter", 32'(caracter), 32'd0);
      check("mrst_columna", 32'(columna), 32'd0);
      check("mrst_fila", 32'(fila), 32'd0);
      check("mrst_mem", 32'(mem[16]), 32'h10);
      cpu_wr_valid = 1'b0;
      rst_n = 1'b1; pos = 0;
      goto(2);
      check("restart_blank", 32'(VGA_blank), 32'd0);
      check("restart_caracter", 32'(caracter), 32'h00);
      check("restart_columna", 32'(columna), 32'd0);
      goto(8); #1;
      check("restart_fetch_addr", 32'(tb_addr), 32'd1);
      goto(19);
      check("restart_caracter17", 32'(caracter), 32'h02);
      check("restart_columna17", 32'(columna), 32'd1);

      // shrunken raster: frame timing and cursor cell
`ifdef CURSOR_BLINK_EN
      exp_cursor = 8'hDB;
`else
      exp_cursor = 8'h03;
`endif
      rst_s_n = 1'b1; pos = 0;
      goto(362);
      check("s_cell3_frame0", 32'(char_s), 32'h03);
      check("s_fila_frame0", 32'(fil_s), 32'd0);
      prev = 1'b1; fall1 = 0; fall2 = 0; vs_low = 0;
      for (int unsigned p = 363; p <= 1600; p++) begin
         goto(p);
         if (prev && !vs_s) begin
            if (fall1 == 0) fall1 = p;
            else if (fall2 == 0) fall2 = p;
         end
         if (!vs_s && p <= 793) vs_low++;
         prev = vs_s;
      end
      check("s_vsync_first_fall", 32'(fall1), 32'd728);
      check("s_frame_length", 32'(fall2 - fall1), 32'd792);
      check("s_vsync_low_cycles", 32'(vs_low), 32'd44);
      goto(31 * 792 + 362);
      check("s_cell3_frame31", 32'(char_s), 32'h03);
      goto(32 * 792 + 362);
      check("s_cell3_frame32", 32'(char_s), 32'(exp_cursor));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/text_scan_sequencer.md
# text_scan_sequencer

Sequencer that drives the VGA text-rendering pipeline.
- Generates 640x480@60 raster timing from the pixel clock.
- Walks an 80x30 text buffer of 8x16 glyph cells, fetching one character code per cell. Presents `caracter`, `columna`, `fila`, `hsync`, `vsync` and `VGA_blank` mutually aligned to the downstream text renderer.
- Shares the single-port text buffer between display fetches (fixed priority) and a CPU write port (valid/ready).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- COLS / ROWS, 80 / 30, text cells (H_ACTIVE/8, V_ACTIVE/16)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  reset, synchronous, active-low
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  write accepted this cycle when valid&ready
- cpu_wr_addr  in  12  cell index, row*COLS+col
- cpu_wr_data  in  8  character code
- cursor_addr  in  12  cursor cell index (used only with CURSOR_BLINK_EN)
- tb_addr  out  12  text buffer address
- tb_we  out  1  text buffer write enable
- tb_wdata  out  8  text buffer write data
- tb_rdata  in  8  text buffer read data, valid 1 cycle after address
- caracter  out  8  character code for current cell
- columna  out  3  pixel column within glyph (0..7)
- fila  out  4  glyph row (0..15)
- hsync / vsync  out  1  active-low syncs
- VGA_blank  out  1  high outside visible area

## Operation
- Internal counters: h (0..799) and v (0..524). h wraps to 0 and v increments; v wraps to 0 after 524.
- Cell tracking:
  - col = h[9:3], row = v/16.
  - Keep a running row_base that adds COLS every 16 visible lines and clears at v wrap. No multiplier.
- Display fetch slot: a cycle with v<V_ACTIVE, h<H_ACTIVE and h[2:0]==0.
  - tb_addr = row_base+col, tb_we=0.
  - In the next cycle tb_rdata is captured into the char register, which holds it for 8 cycles.
- All other cycles are CPU slots.
  - cpu_wr_ready=1 there (combinational from counters), and 0 in fetch slots and during reset.
  - On valid&ready: tb_addr=cpu_wr_addr, tb_wdata=cpu_wr_data, tb_we=1 if cpu_wr_addr<COLS*ROWS.
  - Addresses ≥2400 are accepted (handshake completes) but dropped, tb_we=0.
- Idle CPU slot: tb_we=0; tb_addr holds its last value.
- Raw hsync is low for h in [656,751]; raw vsync is low for v in [490,491]; raw blank = (h≥640)|(v≥480).
- Raw hsync, vsync, blank, h[2:0] and v[3:0] pass through a 2-stage register delay, aligning them with caracter.
- Output bundle at cycle t+2 describes pixel (h,v) from cycle t.
- caracter outside the visible area: value undefined, masked by VGA_blank.

## Timing
- Reset values: h=v=0, row_base=0; hsync=vsync=1, VGA_blank=1, caracter=0, columna=0, fila=0, tb_we=0, tb_addr=0, cpu_wr_ready=0, delay pipes cleared to the same inactive values.
- Reset asserted mid-frame or mid-write takes effect at the next edge. A write presented in that cycle is not performed. Raster restarts at (0,0).
- First pixel after reset release: output (h=0,v=0) appears 2 cycles after the first counting edge.
- Line = 800 cycles, frame = 420000 cycles.
- CPU write latency: tb_we asserted in the same cycle as the handshake.
- Worst-case stall during active lines: 1 cycle per 8.

## Configuration
- CURSOR_BLINK_EN defined:
  - A 6-bit frame counter increments at v wrap; blink phase = counter[5], giving 32 frames on and 32 off.
  - When the phase is on and the fetched cell index equals cursor_addr, the captured char is replaced with 8'hDB.
  - Frame counter resets to 0, phase off.
- Undefined: cursor_addr is ignored, no frame counter, caracter is always tb_rdata.

## Test plan
- Reset release, free run 1 frame -> hsync low exactly 96 cycles per line starting 656+2 cycles after line start; vsync low 2 lines; 800 cycles/line, 525 lines.
- Buffer preloaded with cell index mod 256 -> at output cycle for pixel (h=17,v=35): caracter=8'hA2 (cell 162), columna=1, fila=3.
- cpu_wr_valid held at h=8 on a visible line -> cpu_wr_ready=0 at h=8, write completes at h=9 with tb_we=1 at address 0x005, data 0x41.
- cpu_wr_addr=2400 with valid -> handshake completes, tb_we stays 0, buffer unchanged.
- rst_n pulled low at v=200,h=300 with a write pending -> outputs return to reset values next cycle, no write; raster resumes from (0,0).
- CURSOR_BLINK_EN, cursor_addr=81 -> frames 0-31 show the stored char at cell (1,1); frames 32-63 show 8'hDB there.
